register_file: RTL and testbench

//   Integer register file x0..x31 for the sequential RV64 core.

---
 rtl/register_file_pkg.sv | 26 ++
 rtl/register_file_reg64.sv | 29 ++
 rtl/register_file.sv | 73 +++++++
 tb/tb_register_file.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared definitions for the RV64 integer register file: widths, instruction field positions, decode helper.
// Latency: not applicable (types, constants and a pure function only).
// Backpressure: not applicable.
//
// Contents: XLEN, NREGS, REG_ADDR_W, RS1_LSB/RS2_LSB field positions, REG_ZERO index,
//           decode_onehot() 5-to-32 one-hot decoder used for per-register write enables.
package register_file_pkg;

    localparam int XLEN       = 64;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;

    // Source-register field positions inside the 32-bit instruction word.
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    function automatic logic [NREGS-1:0] decode_onehot(input logic [REG_ADDR_W-1:0] idx);
        logic [NREGS-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/register_file_reg64.sv
// One architectural register: W-bit D register with load enable and asynchronous clear.
// Latency: d_i appears on q_o one clock after en_i is sampled high.
// Backpressure: none; a load is accepted every cycle en_i is high and rst is low.
//
// Ports: clk, rst (async active-high clear), en_i (load enable), d_i (load data), q_o (stored value).
module register_file_reg64 #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // rst wins over any load sampled on the same edge, so a write in flight is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/register_file.sv
// RV64 integer register file x0..x31: two combinational read ports (rs1/rs2 from instruction), one clocked write port.
// Latency: reads are zero-cycle from stored state; writes become visible right after the rising clk edge.
// Backpressure: none; one write per cycle always accepted, writes to x0 silently dropped.
//
// Ports: clk, rst (async active-high), instruction (rs1=[19:15], rs2=[24:20]),
//        reg_write_en / rd_addr / write_data (writeback port), read_data1 / read_data2 (ALU operands).
// Build option: define REGFILE_BYPASS_EN to forward write_data to a read port whose index matches
//               rd_addr in the same cycle; default build returns stored contents only.
module register_file
    import register_file_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instruction,
    input  logic                  reg_write_en,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [XLEN-1:0]       write_data,
    output logic [XLEN-1:0]       read_data1,
    output logic [XLEN-1:0]       read_data2
);

    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [NREGS-1:0]      wr_en_onehot;
    logic [XLEN-1:0]       x_q [NREGS];
    logic [XLEN-1:0]       rd1_mux;
    logic [XLEN-1:0]       rd2_mux;

    assign rs1 = instruction[RS1_LSB +: REG_ADDR_W];
    assign rs2 = instruction[RS2_LSB +: REG_ADDR_W];

    assign wr_en_onehot = reg_write_en ? decode_onehot(rd_addr) : '0;

    // x0 has no storage; its mux input is a constant zero, which also discards writes to index 0.
    assign x_q[0] = '0;

    for (genvar i = 1; i < NREGS; i++) begin : g_xreg
        register_file_reg64 #(
            .W (XLEN)
        ) u_xreg (
            .clk  (clk),
            .rst  (rst),
            .en_i (wr_en_onehot[i]),
            .d_i  (write_data),
            .q_o  (x_q[i])
        );
    end

    always_comb begin
        rd1_mux = x_q[rs1];
        rd2_mux = x_q[rs2];
    end

`ifdef REGFILE_BYPASS_EN
    logic byp1;
    logic byp2;

    // Forwarding is suppressed during reset so the outputs stay at zero while rst is high.
    assign byp1 = !rst && reg_write_en && (rd_addr != REG_ZERO) && (rd_addr == rs1);
    assign byp2 = !rst && reg_write_en && (rd_addr != REG_ZERO) && (rd_addr == rs2);

    assign read_data1 = byp1 ? write_data : rd1_mux;
    assign read_data2 = byp2 ? write_data : rd2_mux;
`else
    assign read_data1 = rd1_mux;
    assign read_data2 = rd2_mux;
`endif

    // Instruction bits outside rs1/rs2 and the x0 enable are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{instruction[31:25], instruction[14:0], wr_en_onehot[0]};

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic        reg_write_en;
    logic [4:0]  rd_addr;
    logic [63:0] write_data;
    logic [63:0] read_data1;
    logic [63:0] read_data2;

    int n_checks = 0;
    int n_pass   = 0;

    register_file dut (
        .clk          (clk),
        .rst          (rst),
        .instruction  (instruction),
        .reg_write_en (reg_write_en),
        .rd_addr      (rd_addr),
        .write_data   (write_data),
        .read_data1   (read_data1),
        .read_data2   (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // R-type word with given rs1/rs2; other fields are arbitrary but fixed.
    function automatic logic [31:0] mk_instr(input logic [4:0] a, input logic [4:0] b);
        return {7'b0, b, a, 3'b000, 5'd0, 7'b0110011};
    endfunction

    function automatic logic [63:0] pat(input int i);
        logic [63:0] v;
        if (i == 0) return 64'd0;
        v = (64'h0101_0101_0101_0101 * 64'(i)) ^ 64'hA5A5_0000_0000_5A5A;
        return v;
    endfunction

    task automatic set_rs(input int a, input int b);
        logic [4:0] a5;
        logic [4:0] b5;
        a5 = a[4:0];
        b5 = b[4:0];
        instruction = mk_instr(a5, b5);
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        @(negedge clk);
        reg_write_en = 1'b1;
        rd_addr      = a;
        write_data   = d;
        @(posedge clk);
        #1;
        reg_write_en = 1'b0;
    endtask

    logic [63:0] exp_pre;
    logic [63:0] alu_out;
    logic [4:0]  rd_field;

    initial begin
        rst          = 1'b0;
        reg_write_en = 1'b0;
        rd_addr      = 5'd0;
        write_data   = 64'd0;
        instruction  = mk_instr(5'd0, 5'd0);
        #1 rst = 1'b1;
        set_rs(5, 31);
        repeat (2) @(negedge clk);
        check("reset_rd1", read_data1, 64'd0);
        check("reset_rd2", read_data2, 64'd0);
        rst = 1'b0;

        // 1. async reset mid-cycle clears preloaded registers
        wr(5'd5, 64'hDEAD);
        wr(5'd31, 64'hFFFF_0000_1234_5678);
        set_rs(5, 31);
        #1;
        check("preload_x5", read_data1, 64'hDEAD);
        check("preload_x31", read_data2, 64'hFFFF_0000_1234_5678);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midcycle_rst_x5", read_data1, 64'd0);
        check("midcycle_rst_x31", read_data2, 64'd0);
        #1 rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            set_rs(i, 31 - i);
            #1;
            check("post_rst_rd1", read_data1, 64'd0);
            check("post_rst_rd2", read_data2, 64'd0);
        end

        // distinct pattern in every register, read back on both ports
        for (int i = 1; i < 32; i++) wr(5'(i), pat(i));
        for (int i = 0; i < 32; i++) begin
            set_rs(i, (i + 7) % 32);
            #1;
            check("pattern_rd1", read_data1, pat(i));
            check("pattern_rd2", read_data2, pat((i + 7) % 32));
        end

        // 2. write/read, rs1 == rs2
        wr(5'd7, 64'h0123_4567_89AB_CDEF);
        set_rs(7, 7);
        #1;
        check("x7_rd1", read_data1, 64'h0123_4567_89AB_CDEF);
        check("x7_rd2", read_data2, 64'h0123_4567_89AB_CDEF);

        // 3. x0 is hardwired zero
        @(negedge clk);
        reg_write_en = 1'b1;
        rd_addr      = 5'd0;
        write_data   = '1;
        set_rs(0, 0);
        #1;
        check("x0_pre_rd1", read_data1, 64'd0);
        check("x0_pre_rd2", read_data2, 64'd0);
        @(posedge clk);
        #1;
        reg_write_en = 1'b0;
        #1;
        check("x0_post_rd1", read_data1, 64'd0);
        check("x0_post_rd2", read_data2, 64'd0);

        // 4. same-cycle write and read of x3
        wr(5'd3, 64'd5);
        @(negedge clk);
        reg_write_en = 1'b1;
        rd_addr      = 5'd3;
        write_data   = 64'd9;
        set_rs(3, 7);
`ifdef REGFILE_BYPASS_EN
        exp_pre = 64'd9;
`else
        exp_pre = 64'd5;
`endif
        #1;
        check("hazard_pre", read_data1, exp_pre);
        check("hazard_other_port", read_data2, 64'h0123_4567_89AB_CDEF);
        @(posedge clk);
        #1;
        reg_write_en = 1'b0;
        #1;
        check("hazard_post", read_data1, 64'd9);

        // write enable low leaves the array unchanged
        wr(5'd6, 64'hAA);
        @(negedge clk);
        reg_write_en = 1'b0;
        rd_addr      = 5'd6;
        write_data   = 64'hBB;
        @(posedge clk);
        #1;
        set_rs(6, 6);
        #1;
        check("wen_low_rd1", read_data1, 64'hAA);
        check("wen_low_rd2", read_data2, 64'hAA);

        // 5. reset dominates a pending write
        @(negedge clk);
        reg_write_en = 1'b1;
        rd_addr      = 5'd4;
        write_data   = 64'h55;
        set_rs(4, 4);
        #2 rst = 1'b1;
        #1;
        check("rst_vs_wr_during", read_data1, 64'd0);
        @(posedge clk);
        #1;
        check("rst_vs_wr_edge", read_data2, 64'd0);
        @(negedge clk);
        rst          = 1'b0;
        reg_write_en = 1'b0;
        #1;
        check("rst_vs_wr_after", read_data1, 64'd0);
        set_rs(6, 6);
        #1;
        check("rst_cleared_x6", read_data1, 64'd0);

        // 6. ALU chain: SLT x3, x1, x2
        wr(5'd1, -64'sd3);
        wr(5'd2, 64'd7);
        instruction = {7'b0000000, 5'd2, 5'd1, 3'b010, 5'd3, 7'b0110011};
        #1;
        check("slt_in1", read_data1, 64'hFFFF_FFFF_FFFF_FFFD);
        check("slt_in2", read_data2, 64'd7);
        alu_out  = ($signed(read_data1) < $signed(read_data2)) ? 64'd1 : 64'd0;
        rd_field = instruction[11:7];
        wr(rd_field, alu_out);
        set_rs(3, 0);
        #1;
        check("slt_x3", read_data1, 64'd1);
        check("slt_x0", read_data2, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
